// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-memory fetch controller.
//   LINE_W   : width of one instruction line (16 bytes)
//   OFFSET_W : byte-offset bits dropped from the fetch address
//   TAG_W    : line-address bits kept as the buffer tag
//   fetch_state_e : fetch FSM states
package fetch_pkg;

  localparam int unsigned LINE_W   = 128;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned TAG_W    = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller with a single-line buffer.
// A frontend request hits the buffered line (one-cycle response) or
// fetches the line from a fixed-latency program memory and buffers it.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   m_rd_en  : fetch request, held until d_valid or abort
//   mem_addr : fetch byte address (low 4 bits ignored)
//   abort    : request cancel; forces IDLE, blocks buffer/counter updates
//   d_valid  : one-cycle pulse, mem_data holds the requested line
//   mem_data : buffered 16-byte line
//   rom_addr : line-aligned program-memory address
//   rom_data : program-memory data, valid LATENCY cycles after rom_addr
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_rd_en,
  input  logic [31:0]       mem_addr,
  input  logic              abort,
  output logic              d_valid,
  output logic [LINE_W-1:0] mem_data,
  output logic [31:0]       rom_addr,
  input  logic [LINE_W-1:0] rom_data
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  fetch_state_e      state_q, state_d;
  logic [3:0]        cnt_q;
  logic [LINE_W-1:0] buf_data_q;
  logic [TAG_W-1:0]  buf_tag_q;
  logic              buf_valid_q;
  logic [31:0]       rom_addr_q;

  logic [TAG_W-1:0]  req_line;
  logic              hit;
  logic              start_miss;
  logic              do_fill;
  logic              cnt_dec;
  logic              unused_offset;

  assign req_line      = mem_addr[31:OFFSET_W];
  assign unused_offset = ^mem_addr[OFFSET_W-1:0];
  assign hit           = buf_valid_q && (buf_tag_q == req_line);

  // Abort overrides every state and suppresses all datapath updates.
  always_comb begin
    state_d    = state_q;
    start_miss = 1'b0;
    do_fill    = 1'b0;
    cnt_dec    = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (m_rd_en) begin
            if (hit) begin
              state_d = RESP;
            end else begin
              state_d    = WAIT;
              start_miss = 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            do_fill = 1'b1;
            state_d = RESP;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      buf_data_q  <= '0;
      buf_tag_q   <= '0;
      buf_valid_q <= 1'b0;
      rom_addr_q  <= '0;
    end else begin
      if (start_miss) begin
        rom_addr_q <= {req_line, {OFFSET_W{1'b0}}};
        cnt_q      <= CNT_INIT;
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // The tag comes from the registered rom_addr so the fill does not
      // depend on the requester still holding mem_addr.
      if (do_fill) begin
        buf_data_q  <= rom_data;
        buf_tag_q   <= rom_addr_q[31:OFFSET_W];
        buf_valid_q <= 1'b1;
      end
    end
  end

  assign d_valid  = (state_q == RESP) && !abort;
  assign mem_data = buf_data_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         m_rd_en = 1'b0;
  logic [31:0]  mem_addr = '0;
  logic         abort = 1'b0;
  logic         d_valid;
  logic [127:0] mem_data;
  logic [31:0]  rom_addr;
  logic [127:0] rom_data;

  int checks = 0;
  int errors = 0;

  // Reference model of the buffered line and the last memory address.
  logic         m_valid = 1'b0;
  logic [27:0]  m_tag = '0;
  logic [127:0] m_data = '0;
  logic [31:0]  m_rom = '0;

  imem_fetch_ctrl #(.LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .m_rd_en  (m_rd_en),
    .mem_addr (mem_addr),
    .abort    (abort),
    .d_valid  (d_valid),
    .mem_data (mem_data),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] line_of(input logic [27:0] n);
    logic [31:0] w;
    w = {4'h0, n};
    return {w, w, w, w};
  endfunction

  // Program memory: data is only correct once rom_addr has been stable
  // for LATENCY cycles; before that it returns junk.
  int          stable_cnt = 0;
  logic [31:0] prev_rom = '0;
  always @(negedge clk) begin
    if (rom_addr !== prev_rom) begin
      stable_cnt <= 0;
      prev_rom   <= rom_addr;
    end else if (stable_cnt < 1000) begin
      stable_cnt <= stable_cnt + 1;
    end
  end
  assign rom_data = (stable_cnt >= LAT - 1) ? line_of(rom_addr[31:4]) : {4{32'hDEAD_BEEF}};

  task automatic model_reset();
    m_valid = 1'b0;
    m_tag   = '0;
    m_data  = '0;
    m_rom   = '0;
  endtask

  task automatic model_fill(input logic [27:0] line);
    m_valid = 1'b1;
    m_tag   = line;
    m_data  = line_of(line);
    m_rom   = {line, 4'h0};
  endtask

  // Issue one request. abort_at/drop_at are edge numbers counted from the
  // first edge after the request is driven (0 = never). chained means the
  // request is driven in the same cycle as the previous d_valid pulse.
  task automatic run_req(input logic [31:0] addr, input int abort_at,
                         input int drop_at, input bit chained, output bit delivered);
    logic [27:0]  line;
    bit           hit;
    int           exp_lat;
    logic [127:0] old_data;
    line      = addr[31:4];
    hit       = m_valid && (m_tag == line);
    exp_lat   = (hit ? 1 : LAT + 1) + (chained ? 1 : 0);
    old_data  = m_data;
    delivered = 1'b0;
    if (!chained) begin
      @(negedge clk);
      checks++;
      if (d_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_dvalid addr=%h got=%b exp=0", addr, d_valid);
      end
    end
    m_rd_en  = 1'b1;
    mem_addr = addr;
    for (int e = 1; e <= exp_lat + 5; e++) begin
      @(negedge clk);
      if (e == drop_at) m_rd_en = 1'b0;
      if (abort_at != 0 && e == abort_at) begin
        abort   = 1'b1;
        m_rd_en = 1'b0;
        #1;
        checks++;
        if (d_valid !== 1'b0) begin
          errors++;
          $display("FAIL abort_dvalid addr=%h edge=%0d got=%b exp=0", addr, e, d_valid);
        end
        @(negedge clk);
        abort = 1'b0;
        if (!hit) begin
          m_rom = {line, 4'h0};
          if (e > LAT) model_fill(line);
        end
        checks++;
        if (d_valid !== 1'b0) begin
          errors++;
          $display("FAIL post_abort_dvalid addr=%h got=%b exp=0", addr, d_valid);
        end
        checks++;
        if (mem_data !== m_data) begin
          errors++;
          $display("FAIL abort_buffer addr=%h got=%h exp=%h", addr, mem_data, m_data);
        end
        checks++;
        if (rom_addr !== m_rom) begin
          errors++;
          $display("FAIL abort_rom_addr addr=%h got=%h exp=%h", addr, rom_addr, m_rom);
        end
        return;
      end
      if (d_valid === 1'b1) begin
        m_rd_en = 1'b0;
        if (!hit) model_fill(line);
        delivered = 1'b1;
        checks++;
        if (e != exp_lat) begin
          errors++;
          $display("FAIL latency addr=%h got=%0d exp=%0d", addr, e, exp_lat);
        end
        checks++;
        if (mem_data !== line_of(line)) begin
          errors++;
          $display("FAIL data addr=%h got=%h exp=%h", addr, mem_data, line_of(line));
        end
        checks++;
        if (rom_addr !== m_rom) begin
          errors++;
          $display("FAIL rom_addr addr=%h got=%h exp=%h", addr, rom_addr, m_rom);
        end
        return;
      end
      if (e < exp_lat) begin
        checks++;
        if (mem_data !== old_data) begin
          errors++;
          $display("FAIL data_stable addr=%h edge=%0d got=%h exp=%h", addr, e, mem_data, old_data);
        end
      end
    end
    errors++;
    $display("FAIL timeout addr=%h got=no_dvalid exp=%0d", addr, exp_lat);
    m_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (d_valid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got=%b exp=0", d_valid); end
    checks++;
    if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
    checks++;
    if (mem_data !== 128'h0) begin errors++; $display("FAIL reset_mem_data got=%h exp=0", mem_data); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_miss_then_hit();
    bit ok;
    run_req(32'h10, 0, 0, 1'b0, ok);
    run_req(32'h1C, 0, 0, ok, ok);
  endtask

  task automatic test_abort_wait();
    bit ok;
    run_req(32'h20, 2, 0, 1'b0, ok);
    checks++;
    if (mem_data !== line_of(28'h1)) begin
      errors++;
      $display("FAIL abort_keeps_line got=%h exp=%h", mem_data, line_of(28'h1));
    end
    run_req(32'h20, 0, 0, 1'b0, ok);
  endtask

  task automatic test_abort_resp();
    bit ok;
    run_req(32'h30, LAT + 1, 0, 1'b0, ok);
    run_req(32'h34, 0, 0, 1'b0, ok);
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    @(negedge clk);
    m_rd_en  = 1'b1;
    mem_addr = 32'h40;
    @(negedge clk);
    m_rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (d_valid !== 1'b0) begin errors++; $display("FAIL midwait_reset_dvalid got=%b exp=0", d_valid); end
    checks++;
    if (rom_addr !== 32'h0) begin errors++; $display("FAIL midwait_reset_rom_addr got=%h exp=0", rom_addr); end
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      checks++;
      if (d_valid !== 1'b0) begin errors++; $display("FAIL in_reset_dvalid cyc=%0d got=%b exp=0", i, d_valid); end
    end
    rst = 1'b1;
    model_reset();
    run_req(32'h30, 0, 0, 1'b0, ok);
  endtask

  task automatic test_abort_idle();
    logic [31:0] rom_before;
    rom_before = m_rom;
    @(negedge clk);
    m_rd_en  = 1'b1;
    abort    = 1'b1;
    mem_addr = 32'h50;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (d_valid !== 1'b0) begin errors++; $display("FAIL abort_idle_dvalid cyc=%0d got=%b exp=0", i, d_valid); end
      checks++;
      if (rom_addr !== rom_before) begin
        errors++;
        $display("FAIL abort_idle_rom_addr cyc=%0d got=%h exp=%h", i, rom_addr, rom_before);
      end
    end
    m_rd_en = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic test_random();
    bit          ok;
    bit          prev_ok;
    logic [31:0] addr;
    logic [3:0]  hi;
    logic [3:0]  ln;
    bit          hit;
    int          abort_at;
    int          drop_at;
    int          r;
    bit          chained;
    prev_ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      hi   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h0;
      ln   = 4'($urandom_range(0, 5));
      addr = {hi, 20'h0, ln, 4'($urandom_range(0, 15))};
      hit  = m_valid && (m_tag == addr[31:4]);
      r    = $urandom_range(0, 7);
      abort_at = 0;
      drop_at  = 0;
      if (r == 0) abort_at = $urandom_range(1, hit ? 1 : LAT + 1);
      if (r == 1 && !hit) drop_at = $urandom_range(2, LAT);
      chained = prev_ok && (abort_at == 0) && ($urandom_range(0, 1) == 1);
      if (abort_at != 0 && prev_ok) chained = 1'b0;
      run_req(addr, abort_at, drop_at, chained, ok);
      prev_ok = ok;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    run_req(32'h60, 0, 0, 1'b0, ok);
    run_req(32'h64, 0, 0, ok, ok);
    run_req(32'h70, 0, 0, ok, ok);
    run_req(32'h68, 0, 0, ok, ok);
  endtask

  initial begin
    test_reset();
    test_miss_then_hit();
    test_abort_wait();
    test_abort_resp();
    test_reset_mid_wait();
    test_abort_idle();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
